i2c_read_sequencer: RTL
=======================

# i2c_read_sequencer

Controls the slave-transmit (master-read) phase of the I2C peripheral. After address decode accepts a read, it fetches bytes from the register file, loads and clocks the byte transmitter one bit per SCL low period, releases SDA for the master's ACK/NACK, and repeats until NACK or STOP. It sits directly upstream of the byte transmitter, drives that block's load (`reset`) and `enable` inputs, and owns the SDA output-enable.

## Interface
- COUNT_WIDTH, 8, width of the transferred-byte counter
- clk  in  1  system clock; must be ≥ 8× SCL frequency
- reset  in  1  synchronous, active-high
- scl  in  1  SCL, already synchronized to clk
- sda_in  in  1  SDA, already synchronized to clk
- start  in  1  one-cycle pulse from address decode: read accepted and address ACK's SCL falling edge has passed, so SCL is low
- stop  in  1  one-cycle pulse from bus condition detector: STOP or repeated START seen
- data_in  in  8  register-file read data, valid the cycle after data_req
- data_req  out  1  one-cycle request for the next byte
- tx_load  out  1  to the transmitter's `reset`: captures data_in
- tx_enable  out  1  to the transmitter's `enable`: shift one bit out
- sda_oe  out  1  1 = pad drives transmitter bit (open-drain low on 0); 0 = released
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of transfer on master NACK
- byte_count  out  COUNT_WIDTH  bytes ACKed by master since last start

## Operation
- All outputs registered. Reset values: data_req, tx_load, tx_enable, sda_oe, busy, done = 0; byte_count = 0; internal scl_prev = 1; state IDLE.
- Edge detect: fall = scl_prev & ~scl; rise = ~scl_prev & scl; scl_prev updated every cycle.
- States:
  - IDLE: start → FETCH, byte_count cleared to 0. Other inputs ignored.
  - FETCH (1 cycle): data_req = 1 → LOAD.
  - LOAD (1 cycle): tx_load = 1 (data_in valid this cycle) → PRIME.
  - PRIME (1 cycle): tx_enable = 1 (presents bit 7), bit_cnt = 1 → SHIFT; sda_oe set next cycle.
  - SHIFT: on fall, if bit_cnt < 8: tx_enable = 1, bit_cnt += 1; if bit_cnt == 8: sda_oe = 0 → ACK.
  - ACK: on rise, sample sda_in. 0 → ACK_HOLD. 1 (NACK) → done = 1 → IDLE.
  - ACK_HOLD: on fall → byte_count += 1 (wraps modulo 2^COUNT_WIDTH) → FETCH.
- Priority: reset > stop > state logic. stop in any non-IDLE state → IDLE next cycle, sda_oe = 0, done not pulsed, byte_count held.
- start while busy: ignored.
- Exactly 8 tx_enable pulses per byte; the byte transmitter is never enabled outside PRIME/SHIFT.

## Timing
- start in cycle S: data_req in S+1, tx_load in S+2, tx_enable in S+3, sda_oe = 1 from S+4 (bit 7 valid on pad with sda_oe).
- Falling edge first sampled in cycle E (scl = 0, scl_prev = 1): tx_enable in E+1, new bit on transmitter output from E+2.
- 8th falling edge in cycle E: sda_oe = 0 from E+1.
- ACK sampled in the first cycle with rise; NACK → done high in the next cycle, busy low the cycle after.
- ACK_HOLD fall in cycle E: byte_count updated and data_req in E+1; next byte's bit 7 reaches the pad by E+4, within the SCL low period given the clock ratio.
- stop in cycle T: busy = 0 and sda_oe = 0 from T+1.

## Test plan
- Single byte: start, data_in = 0xA5, 8 SCL pulses, master NACK → pad bits 1,0,1,0,0,1,0,1 on successive SCL highs; exactly 8 tx_enable; done pulse; byte_count = 0.
- Two bytes: 0x3C ACKed, 0xFF NACKed → 2 data_req pulses, byte_count = 1 at done, SDA released during both ACK clocks.
- Cycle timing: start at cycle 10 → data_req 11, tx_load 12, tx_enable 13, sda_oe 14.
- STOP mid-byte after 4 bits → IDLE next cycle, sda_oe = 0, no done, no further tx_enable; new start works normally.
- Reset asserted during ACK_HOLD → all outputs 0 next cycle, byte_count = 0; start during busy ignored (no extra data_req).
- Wrap: COUNT_WIDTH = 2, 5 ACKed bytes then NACK → byte_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/i2c_read_sequencer.sv
// i2c_read_sequencer
// Sequences the slave-transmit phase of an I2C read: fetches each byte from
// the register file, loads and clocks the byte transmitter one bit per SCL
// low period, releases SDA for the master's ACK/NACK and repeats until the
// master NACKs or a STOP / repeated START ends the transfer.
module i2c_read_sequencer #(
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   scl,
  input  logic                   sda_in,
  input  logic                   start,
  input  logic                   stop,
  input  logic [7:0]             data_in,
  output logic                   data_req,
  output logic                   tx_load,
  output logic                   tx_enable,
  output logic                   sda_oe,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] byte_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    LOAD     = 3'd2,
    PRIME    = 3'd3,
    SHIFT    = 3'd4,
    ACK      = 3'd5,
    ACK_HOLD = 3'd6
  } state_t;

  state_t     state;
  logic       scl_prev;
  logic       fall;
  logic       rise;
  logic [3:0] bit_cnt;
  logic       unused_data;

  assign fall = scl_prev & ~scl;
  assign rise = ~scl_prev & scl;

  // data_in is wired straight to the transmitter; this block only times its capture
  assign unused_data = ^data_in;

  // SCL history for edge detection
  always_ff @(posedge clk) begin
    if (reset) scl_prev <= 1'b1;
    else       scl_prev <= scl;
  end

  // Transfer FSM; every output is registered, pulses default low each cycle.
  // busy stays high for the cycle carrying done and drops in the following one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      data_req   <= 1'b0;
      tx_load    <= 1'b0;
      tx_enable  <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bit_cnt    <= '0;
      byte_count <= '0;
    end else begin
      data_req  <= 1'b0;
      tx_load   <= 1'b0;
      tx_enable <= 1'b0;
      done      <= 1'b0;
      if (stop && (state != IDLE)) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
            if (start && !busy) begin
              state      <= FETCH;
              data_req   <= 1'b1;
              busy       <= 1'b1;
              byte_count <= '0;
            end
          end
          FETCH: begin
            tx_load <= 1'b1;
            state   <= LOAD;
          end
          LOAD: begin
            tx_enable <= 1'b1;
            state     <= PRIME;
          end
          PRIME: begin
            sda_oe  <= 1'b1;
            bit_cnt <= 4'd1;
            state   <= SHIFT;
          end
          SHIFT: begin
            if (fall) begin
              if (bit_cnt < 4'd8) begin
                tx_enable <= 1'b1;
                bit_cnt   <= bit_cnt + 4'd1;
              end else begin
                sda_oe <= 1'b0;
                state  <= ACK;
              end
            end
          end
          ACK: begin
            if (rise) begin
              if (!sda_in) begin
                state <= ACK_HOLD;
              end else begin
                done  <= 1'b1;
                state <= IDLE;
              end
            end
          end
          ACK_HOLD: begin
            if (fall) begin
              byte_count <= byte_count + 1'b1;
              data_req   <= 1'b1;
              state      <= FETCH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
